// File: rtl/plru_tree_replacement.sv
// Tree pseudo-LRU victim selector with per-set tree bits and a self-timed clearing sweep.
// Define PLRU_STATS_EN to add saturating hit/miss counters with a synchronous clear.
module plru_tree_replacement #(
    parameter int INDEX_WIDTH = 8,
    parameter int WAY_WIDTH   = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        flush,
    input  logic                        update,
    input  logic                        hit_update,
    input  logic [INDEX_WIDTH-1:0]      index,
    input  logic [WAY_WIDTH-1:0]        hit_way,
    input  logic [(1<<WAY_WIDTH)-1:0]   valid_vec,
`ifdef PLRU_STATS_EN
    input  logic                        stats_clr,
    output logic [CNT_WIDTH-1:0]        hit_count,
    output logic [CNT_WIDTH-1:0]        miss_count,
`endif
    output logic [WAY_WIDTH-1:0]        replace_way,
    output logic                        busy
);

    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WAYS  = 1 << WAY_WIDTH;
    localparam int NODES = WAYS - 1;

    typedef enum logic {INIT, READY} state_t;

    state_t                 state, next_state;
    logic [INDEX_WIDTH-1:0] cnt;
    logic [NODES-1:0]       tree_mem [SETS];
    logic [NODES-1:0]       cur_bits;
    logic [NODES-1:0]       new_bits;
    logic [WAY_WIDTH-1:0]   tree_way;
    logic [WAY_WIDTH-1:0]   free_way;
    logic [WAY_WIDTH-1:0]   victim;
    logic [WAY_WIDTH-1:0]   access_way;
    logic                   all_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT:    if (cnt == INDEX_WIDTH'(SETS - 1)) next_state = READY;
            READY:   if (flush) next_state = INIT;
            default: next_state = INIT;
        endcase
    end

    // The sweep counter wraps back to 0 on its last write, so READY always starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= '0;
        else if (state == INIT)  cnt <= cnt + 1'b1;
        else if (flush)          cnt <= '0;
    end

    assign cur_bits = tree_mem[index];

    always_comb begin
        int  node;
        logic b;
        tree_way = '0;
        node     = 0;
        b        = 1'b0;
        for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
            b = 1'b0;
            for (int n = 0; n < NODES; n++)
                if (n == node) b = cur_bits[n];
            tree_way[WAY_WIDTH-1-lvl] = b;
            node = 2 * node + 1 + (b ? 1 : 0);
        end
    end

    // Lowest-numbered invalid way; only used when at least one way is invalid.
    always_comb begin
        all_valid = &valid_vec;
        free_way  = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid_vec[i]) free_way = WAY_WIDTH'(i);
    end

    assign victim     = all_valid ? tree_way : free_way;
    assign access_way = hit_update ? hit_way : victim;

    always_comb begin
        int  node;
        logic d;
        new_bits = cur_bits;
        node     = 0;
        d        = 1'b0;
        for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
            d = access_way[WAY_WIDTH-1-lvl];
            for (int n = 0; n < NODES; n++)
                if (n == node) new_bits[n] = ~d;
            node = 2 * node + 1 + (d ? 1 : 0);
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT)  tree_mem[cnt]   <= '0;
        else if (update)    tree_mem[index] <= new_bits;
    end

    assign busy        = (state == INIT);
    assign replace_way = (en && state == READY) ? victim : '0;

`ifdef PLRU_STATS_EN
    // Clearing (explicit or via flush) takes priority over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (stats_clr || (state == READY && flush)) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == READY && update) begin
            if (hit_update && hit_count != '1)   hit_count  <= hit_count + 1'b1;
            if (!hit_update && miss_count != '1) miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_plru_tree_replacement.sv
// Self-checking bench for plru_tree_replacement: directed scenarios plus a randomized phase
// compared against a per-level direction model of the pseudo-LRU tree.
module tb_plru_tree_replacement;

    localparam int IW   = 8;
    localparam int WW   = 2;
    localparam int WAYS = 4;
    localparam int SETS = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            flush = 1'b0;
    logic            update = 1'b0;
    logic            hit_update = 1'b0;
    logic [IW-1:0]   index = '0;
    logic [WW-1:0]   hit_way = '0;
    logic [WAYS-1:0] valid_vec = '1;
    logic [WW-1:0]   replace_way;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // dir[set][level][prefix]: 1 means the victim lies in the upper half of that way range.
    int dir [SETS][WW][WAYS/2];

    always #5 clk = ~clk;

    plru_tree_replacement #(.INDEX_WIDTH(IW), .WAY_WIDTH(WW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .update(update),
        .hit_update(hit_update), .index(index), .hit_way(hit_way),
        .valid_vec(valid_vec), .replace_way(replace_way), .busy(busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_victim(input int set, input logic [WAYS-1:0] vv);
        int v;
        if (vv != '1) begin
            for (int i = 0; i < WAYS; i++)
                if (!vv[i]) return i;
        end
        v = 0;
        for (int l = 0; l < WW; l++) v = v * 2 + dir[set][l][v];
        return v;
    endfunction

    task automatic model_touch(input int set, input int way);
        for (int l = 0; l < WW; l++)
            dir[set][l][way >> (WW - l)] = ((way >> (WW - 1 - l)) & 1) ? 0 : 1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int l = 0; l < WW; l++)
                for (int p = 0; p < WAYS / 2; p++) dir[s][l][p] = 0;
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic op(input string tag, input int set, input bit upd, input bit hu,
                      input int hw, input logic [WAYS-1:0] vv, input bit e, input int exp_c);
        int raw;
        int exp;
        index      = IW'(set);
        update     = upd;
        hit_update = hu;
        hit_way    = WW'(hw);
        valid_vec  = vv;
        en         = e;
        @(negedge clk);
        raw = model_victim(set, vv);
        exp = (exp_c >= 0) ? exp_c : (e ? raw : 0);
        check(tag, int'(replace_way), exp);
        @(posedge clk); #1;
        update = 1'b0;
        if (upd) model_touch(set, hu ? hw : raw);
    endtask

    // Counts busy cycles; optionally pulses flush mid-sweep, which must be ignored.
    task automatic wait_sweep(input string tag, input int flush_at);
        int n;
        int rw_bad;
        n      = 0;
        rw_bad = 0;
        forever begin
            @(negedge clk);
            flush = 1'b0;
            if (!busy || n > 2000) break;
            if (replace_way !== '0) rw_bad = 1;
            n++;
            if (n == flush_at) flush = 1'b1;
        end
        update = 1'b0;
        flush  = 1'b0;
        check(tag, n, 256);
        check({tag, "_rw_zero"}, rw_bad, 0);
        @(posedge clk); #1;
        model_clear();
    endtask

    initial begin
        int mseq [5];
        mseq = '{0, 2, 1, 3, 0};
        model_clear();

        en = 1'b1;
        #23;
        check("reset_busy", int'(busy), 1);
        check("reset_rw", int'(replace_way), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_sweep("init_sweep", 0);

        for (int i = 0; i < 3; i++) op("iso_miss", 1, 1'b1, 1'b0, 0, '1, 1'b1, -1);
        op("iso_set0", 0, 1'b0, 1'b0, 0, '1, 1'b1, 0);

        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_sweep("flush_sweep", 50);
        op("flush_set1", 1, 1'b0, 1'b0, 0, '1, 1'b1, 0);

        for (int i = 0; i < 5; i++) op($sformatf("miss_seq%0d", i), 0, 1'b1, 1'b0, 0, '1, 1'b1, mseq[i]);

        op("hit3", 2, 1'b1, 1'b1, 3, '1, 1'b1, 0);
        op("hit_then_miss", 2, 1'b1, 1'b0, 0, '1, 1'b1, 0);
        op("hit_next", 2, 1'b0, 1'b0, 0, '1, 1'b1, 2);

        op("inv_prep", 4, 1'b1, 1'b1, 0, '1, 1'b1, 0);
        op("inv_peek", 4, 1'b0, 1'b0, 0, 4'b1011, 1'b1, 2);
        op("inv_miss", 4, 1'b1, 1'b0, 0, 4'b1011, 1'b1, 2);
        op("inv_tree", 4, 1'b0, 1'b0, 0, '1, 1'b1, 1);
        op("inv_low", 4, 1'b0, 1'b0, 0, 4'b0110, 1'b1, 0);

        op("en_off", 5, 1'b1, 1'b0, 0, '1, 1'b0, 0);
        op("en_on", 5, 1'b0, 1'b0, 0, '1, 1'b1, 2);

        flush = 1'b1;
        @(posedge clk); #1;
        flush      = 1'b0;
        index      = IW'(3);
        update     = 1'b1;
        hit_update = 1'b1;
        hit_way    = 2'd1;
        valid_vec  = '1;
        en         = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #2;
        check("midrst_busy", int'(busy), 1);
        check("midrst_rw", int'(replace_way), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_sweep("midrst_sweep", 0);
        op("midrst_set3a", 3, 1'b1, 1'b0, 0, '1, 1'b1, 0);
        op("midrst_set3b", 3, 1'b0, 1'b0, 0, '1, 1'b1, 2);

        for (int i = 0; i < 300; i++) begin
            logic [WAYS-1:0] vv;
            vv = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '1;
            op("random", int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, WAYS - 1)), vv,
               ($urandom_range(0, 3) != 0), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
